// File: rtl/region_flasher.sv
// Continuation-driven copy engine: walks an inclusive, screen-clamped window of the
// framebuffer one pixel at a time and issues one vga_adapter plot per pixel.
//
// state | meaning
// IDLE  | waiting for in_cont_signal; latches and clamps the window
// ADDR  | read_addr holds the current pixel address
// WAIT  | RD_LAT-cycle down-count for framebuffer data; last edge captures it
// PLOT  | vga_plot strobe (suppressed on key match); advance cx/cy
// DONE  | out_cont_signal held until next_fin_signal
module region_flasher #(
    parameter int SCR_W      = 160,
    parameter int SCR_H      = 120,
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 7,
    parameter int COLOR_BITS = 3,
    parameter int ADDR_BITS  = 15,
    parameter int RD_LAT     = 1
) (
    input  logic                  Clck,
    input  logic                  Reset,
    input  logic                  in_cont_signal,
    input  logic [X_BITS-1:0]     win_x0,
    input  logic [Y_BITS-1:0]     win_y0,
    input  logic [X_BITS-1:0]     win_x1,
    input  logic [Y_BITS-1:0]     win_y1,
    input  logic                  key_en,
    input  logic [COLOR_BITS-1:0] key_colour,
    output logic [ADDR_BITS-1:0]  read_addr,
    input  logic [COLOR_BITS-1:0] read_data,
    output logic [X_BITS-1:0]     vga_x,
    output logic [Y_BITS-1:0]     vga_y,
    output logic [COLOR_BITS-1:0] vga_colour,
    output logic                  vga_plot,
    output logic                  busy,
    output logic                  win_err,
    output logic                  out_cont_signal,
    input  logic                  next_fin_signal
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [X_BITS-1:0] X_MAX = X_BITS'(SCR_W - 1);
    localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(SCR_H - 1);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, PLOT, DONE} state_t;

    state_t                state, state_next;
    logic [X_BITS-1:0]     cx, cx_next, x0, x0_next, x1, x1_next;
    logic [Y_BITS-1:0]     cy, cy_next, y0, y0_next, y1, y1_next;
    logic                  key_en_q, key_en_next;
    logic [COLOR_BITS-1:0] key_q, key_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [ADDR_BITS-1:0]  read_addr_next;
    logic [X_BITS-1:0]     vga_x_next;
    logic [Y_BITS-1:0]     vga_y_next;
    logic [COLOR_BITS-1:0] vga_colour_next;
    logic                  vga_plot_next, busy_next, win_err_next, out_cont_next;
    logic [X_BITS-1:0]     x1_clamp;
    logic [Y_BITS-1:0]     y1_clamp;

    assign x1_clamp = (win_x1 > X_MAX) ? X_MAX : win_x1;
    assign y1_clamp = (win_y1 > Y_MAX) ? Y_MAX : win_y1;

    always_ff @(posedge Clck) begin
        if (!Reset) begin
            state           <= IDLE;
            cx              <= '0;
            cy              <= '0;
            x0              <= '0;
            y0              <= '0;
            x1              <= '0;
            y1              <= '0;
            key_en_q        <= 1'b0;
            key_q           <= '0;
            cnt             <= '0;
            read_addr       <= '0;
            vga_x           <= '0;
            vga_y           <= '0;
            vga_colour      <= '0;
            vga_plot        <= 1'b0;
            busy            <= 1'b0;
            win_err         <= 1'b0;
            out_cont_signal <= 1'b0;
        end else begin
            state           <= state_next;
            cx              <= cx_next;
            cy              <= cy_next;
            x0              <= x0_next;
            y0              <= y0_next;
            x1              <= x1_next;
            y1              <= y1_next;
            key_en_q        <= key_en_next;
            key_q           <= key_next;
            cnt             <= cnt_next;
            read_addr       <= read_addr_next;
            vga_x           <= vga_x_next;
            vga_y           <= vga_y_next;
            vga_colour      <= vga_colour_next;
            vga_plot        <= vga_plot_next;
            busy            <= busy_next;
            win_err         <= win_err_next;
            out_cont_signal <= out_cont_next;
        end
    end

    always_comb begin
        state_next      = state;
        cx_next         = cx;
        cy_next         = cy;
        x0_next         = x0;
        y0_next         = y0;
        x1_next         = x1;
        y1_next         = y1;
        key_en_next     = key_en_q;
        key_next        = key_q;
        cnt_next        = cnt;
        vga_x_next      = vga_x;
        vga_y_next      = vga_y;
        vga_colour_next = vga_colour;
        vga_plot_next   = 1'b0;
        win_err_next    = win_err;
        out_cont_next   = out_cont_signal;

        case (state)
            IDLE: begin
                if (in_cont_signal) begin
                    x0_next     = win_x0;
                    y0_next     = win_y0;
                    x1_next     = x1_clamp;
                    y1_next     = y1_clamp;
                    key_en_next = key_en;
                    key_next    = key_colour;
                    if ((win_x0 > x1_clamp) || (win_y0 > y1_clamp)) begin
                        win_err_next  = 1'b1;
                        out_cont_next = 1'b1;
                        state_next    = DONE;
                    end else begin
                        win_err_next = 1'b0;
                        cx_next      = win_x0;
                        cy_next      = win_y0;
                        state_next   = ADDR;
                    end
                end
            end
            ADDR: begin
                cnt_next   = CNT_W'(RD_LAT - 1);
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    vga_colour_next = read_data;
                    vga_x_next      = cx;
                    vga_y_next      = cy;
                    vga_plot_next   = !(key_en_q && (read_data == key_q));
                    state_next      = PLOT;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            PLOT: begin
                if ((cx == x1) && (cy == y1)) begin
                    out_cont_next = 1'b1;
                    state_next    = DONE;
                end else begin
                    if (cx == x1) begin
                        cx_next = x0;
                        cy_next = cy + 1'b1;
                    end else begin
                        cx_next = cx + 1'b1;
                    end
                    state_next = ADDR;
                end
            end
            DONE: begin
                if (next_fin_signal) begin
                    out_cont_next = 1'b0;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next == ADDR) || (state_next == WAIT) || (state_next == PLOT);
        // Address is loaded on entry to ADDR so it is already valid during that cycle.
        if (state_next == ADDR)
            read_addr_next = ADDR_BITS'(32'(cy_next) * 32'(SCR_W) + 32'(cx_next));
        else
            read_addr_next = read_addr;
    end

endmodule
